// File: rtl/conv_sched.sv
// Frame-level sequencer for the ConvLayer_calc datapath: issues one kernel window per
// handshake, tags returning results with their output row/column, and flags drain errors.
module conv_sched #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int KERNEL = 3,
   parameter int LAT    = 4,
   parameter int CW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          win_valid,
   output logic          win_ready,
   output logic          calc_en,
   input  logic          calc_en_out,
   output logic          out_valid,
   output logic [CW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int OW = IMG_W - KERNEL + 1;
   localparam int OH = IMG_H - KERNEL + 1;
   localparam logic [CW-1:0] OW_M1 = CW'(OW - 1);
   localparam logic [CW-1:0] OH_M1 = CW'(OH - 1);
   localparam int TW = $clog2(LAT + 3);
   // The timeout window is LAT+2 cycles counted from the result cycle itself,
   // so the register is loaded one lower than the window length.
   localparam logic [TW-1:0] TMO_LOAD = TW'(LAT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] iss_row, iss_col;
   logic [CW-1:0] res_row, res_col;
   logic [TW-1:0] tmo;
   logic          res_seen;
   logic          iss_at_last, res_at_last;

   assign win_ready   = (state == RUN);
   assign busy        = (state == RUN) || (state == DRAIN);
   assign done        = (state == DONE);
   assign calc_en     = win_valid & win_ready;
   assign out_valid   = calc_en_out & busy;
   assign out_row     = res_row;
   assign out_col     = res_col;
   assign iss_at_last = (iss_row == OH_M1) && (iss_col == OW_M1);
   assign res_at_last = (res_row == OH_M1) && (res_col == OW_M1);
   assign out_last    = out_valid & res_at_last;

   // NOTE: state registers use non-blocking assignment only, so every read in this
   // block sees the pre-edge value and several assignments to one register resolve
   // to the last one executed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         iss_row  <= '0;
         iss_col  <= '0;
         res_row  <= '0;
         res_col  <= '0;
         tmo      <= '0;
         res_seen <= 1'b0;
         err      <= 1'b0;
      end else if (abort) begin
         state    <= IDLE;
         iss_row  <= '0;
         iss_col  <= '0;
         res_row  <= '0;
         res_col  <= '0;
         tmo      <= '0;
         res_seen <= 1'b0;
      end else begin
         if (calc_en) begin
            if (iss_col == OW_M1) begin
               iss_col <= '0;
               iss_row <= (iss_row == OH_M1) ? '0 : iss_row + CW'(1);
            end else begin
               iss_col <= iss_col + CW'(1);
            end
         end
         if (out_valid) begin
            if (res_col == OW_M1) begin
               res_col <= '0;
               res_row <= (res_row == OH_M1) ? '0 : res_row + CW'(1);
            end else begin
               res_col <= res_col + CW'(1);
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  iss_row  <= '0;
                  iss_col  <= '0;
                  res_row  <= '0;
                  res_col  <= '0;
                  res_seen <= 1'b0;
                  err      <= 1'b0;
               end
            end
            RUN: begin
               if (out_valid && res_at_last) res_seen <= 1'b1;
               // A short datapath may deliver the final result before the final issue.
               if (calc_en && iss_at_last) begin
                  if (res_seen || (out_valid && res_at_last)) begin
                     state <= DONE;
                  end else begin
                     state <= DRAIN;
                     tmo   <= TMO_LOAD;
                  end
               end
            end
            DRAIN: begin
               if (out_valid) begin
                  tmo <= TMO_LOAD;
                  if (res_at_last) state <= DONE;
               end else if (tmo <= TW'(1)) begin
                  state <= DONE;
                  err   <= 1'b1;
               end else begin
                  tmo <= tmo - TW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               res_seen <= 1'b0;
            end
         endcase

         // Stray results outside a frame are an error; this wins over the start clear.
         if (calc_en_out && !busy) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: a latency-4 datapath model with drop/inject hooks and
// a negedge monitor that records issues, result tags and done timing per frame.
module tb_conv_sched;

   localparam int LAT = 4;
   localparam int OW  = 6;
   localparam int NW  = 36;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       win_valid = 1'b0;
   logic       inject = 1'b0;
   logic       drop_last = 1'b0;
   logic       win_ready, calc_en, calc_en_out, out_valid, out_last, busy, done, err;
   logic [7:0] out_row, out_col;
   logic [LAT-1:0] pipe = '0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0;

   typedef struct {int row; int col; logic last;} obs_t;
   obs_t obs_q[$];
   int   n_iss = 0, n_done = 0, last_iss = 0, last_res = 0, done_at = 0, wr_fall = 0;
   logic err_at_done = 1'b0, busy_at_done = 1'b0, prev_wr = 1'b0;

   conv_sched dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .win_valid(win_valid), .win_ready(win_ready), .calc_en(calc_en),
      .calc_en_out(calc_en_out), .out_valid(out_valid), .out_row(out_row),
      .out_col(out_col), .out_last(out_last), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: fixed latency, optionally swallowing the 36th window of a frame.
   always @(posedge clk) pipe <= {pipe[LAT-2:0], calc_en & ~(drop_last & (n_iss == NW))};
   assign calc_en_out = pipe[LAT-1] | inject;

   always @(negedge clk) begin
      if (start && !busy) begin
         obs_q.delete();
         n_iss = 0; n_done = 0; last_iss = 0; last_res = 0; done_at = 0; wr_fall = 0;
      end
      if (calc_en) begin
         n_iss++;
         last_iss = cyc;
      end
      if (prev_wr && !win_ready) wr_fall = cyc;
      prev_wr = win_ready;
      if (out_valid) begin
         obs_q.push_back('{int'(out_row), int'(out_col), out_last});
         last_res = cyc;
      end
      if (done) begin
         n_done++;
         done_at      = cyc;
         err_at_done  = err;
         busy_at_done = busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit toggle);
      int k = 0;
      while (n_done == 0 && k < budget) begin
         tick();
         if (toggle) win_valid = ~win_valid;
         k++;
      end
      check("done_seen", n_done > 0, 1);
   endtask

   task automatic check_tags(input int n);
      check("n_results", obs_q.size(), n);
      for (int i = 0; i < obs_q.size(); i++) begin
         check("tag_row", obs_q[i].row, i / OW);
         check("tag_col", obs_q[i].col, i % OW);
         check("tag_last", obs_q[i].last, i == NW - 1);
      end
   endtask

   initial begin
      #1;
      check("rst_win_ready", win_ready, 0);
      check("rst_calc_en", calc_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_col", out_col, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Continuous windows: 36 back-to-back issues, done at t+41.
      win_valid = 1'b1;
      start_frame();
      check("t1_win_ready", win_ready, 1);
      check("t1_busy", busy, 1);
      wait_done(100, 1'b0);
      check("t1_n_iss", n_iss, NW);
      check("t1_last_iss", last_iss - t0, 36);
      check("t1_wr_fall", wr_fall - t0, 37);
      check("t1_done_at", done_at - t0, 41);
      check("t1_err", err_at_done, 0);
      check("t1_busy_at_done", busy_at_done, 0);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_done", done, 0);
      check_tags(NW);

      // Alternating windows: last issue at t+71, done one cycle after the last result.
      start_frame();
      wait_done(200, 1'b1);
      win_valid = 1'b1;
      check("t2_n_iss", n_iss, NW);
      check("t2_last_iss", last_iss - t0, 71);
      check("t2_done_gap", done_at - last_res, 1);
      check("t2_err", err_at_done, 0);
      check_tags(NW);

      // Final result dropped: timeout fires LAT+2 cycles after the 35th result.
      drop_last = 1'b1;
      start_frame();
      wait_done(100, 1'b0);
      drop_last = 1'b0;
      check("t3_last_res", last_res - t0, 39);
      check("t3_done_gap", done_at - last_res, 6);
      check("t3_err", err_at_done, 1);
      check_tags(NW - 1);

      // Abort on the 10th issue; in-flight results then land in IDLE and flag err.
      start_frame();
      repeat (9) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_win_ready", win_ready, 0);
      check("t4_busy", busy, 0);
      repeat (8) tick();
      check("t4_n_iss", n_iss, 10);
      check("t4_no_done", n_done, 0);
      check("t4_err", err, 1);
      check_tags(6);
      start_frame();
      check("t4_err_clr", err, 0);
      wait_done(100, 1'b0);
      check("t4_done_at", done_at - t0, 41);
      check_tags(NW);

      // Stray result in IDLE.
      tick();
      inject = 1'b1;
      #1;
      check("t5_out_valid", out_valid, 0);
      tick();
      inject = 1'b0;
      check("t5_err", err, 1);
      start_frame();
      check("t5_err_clr", err, 0);
      wait_done(100, 1'b0);
      check_tags(NW);

      // Reset during DRAIN, then a clean frame.
      start_frame();
      repeat (37) tick();
      check("t6_in_drain", busy && !win_ready, 1);
      rst = 1'b0;
      #1;
      check("t6_win_ready", win_ready, 0);
      check("t6_calc_en", calc_en, 0);
      check("t6_out_valid", out_valid, 0);
      check("t6_out_row", out_row, 0);
      check("t6_out_col", out_col, 0);
      check("t6_out_last", out_last, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_err", err, 0);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      check("t6_post_err", err, 0);
      check("t6_post_busy", busy, 0);
      check("t6_no_done", n_done, 0);
      start_frame();
      wait_done(100, 1'b0);
      check("t6_done_at", done_at - t0, 41);
      check("t6_err_end", err_at_done, 0);
      check_tags(NW);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
